// File: rtl/mux_read_arbiter.sv
// Round-robin arbiter sharing one select-driven word mux between NUM_REQ readers.
// Two stages: grant/select register, then captured response with valid/ready hold.
module mux_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 5,
    parameter int ID_WIDTH   = 2
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*SEL_WIDTH-1:0]   req_sel,
    output logic [NUM_REQ-1:0]             grant,
    output logic [SEL_WIDTH-1:0]           mux_select,
    input  logic [DATA_WIDTH-1:0]          mux_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]      prio_ptr_q, prio_ptr_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic                  found;
    logic [PTR_W-1:0]      win_idx;
    logic [PTR_W:0]        scan_idx;
    logic [SEL_WIDTH-1:0]  win_sel;
    logic                  s1_adv;
    logic                  s2_adv;
    logic                  accept;

    assign s2_adv = !rsp_valid_q || rsp_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    // Scan starts at the priority pointer and wraps; first pending request wins.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, prio_ptr_q} + (PTR_W + 1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!found && req[scan_idx[PTR_W-1:0]]) begin
                found   = 1'b1;
                win_idx = scan_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_sel = req_sel[i*SEL_WIDTH +: SEL_WIDTH];
            end
        end
    end

    assign accept = found && s1_adv && reset_n;

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = accept && (win_idx == PTR_W'(i));
        end
    end

    always_comb begin
        prio_ptr_d  = prio_ptr_q;
        s1_valid_d  = s1_valid_q;
        sel_d       = sel_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;

        if (s2_adv) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_data_d = mux_data;
                rsp_id_d   = id_q;
            end
        end

        // Select is left untouched when stage 1 drains so the shared mux stays quiet.
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                sel_d      = win_sel;
                id_d       = ID_WIDTH'(win_idx);
                prio_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_ptr_q  <= '0;
            s1_valid_q  <= 1'b0;
            sel_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            prio_ptr_q  <= prio_ptr_d;
            s1_valid_q  <= s1_valid_d;
            sel_q       <= sel_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign mux_select = sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

    a_grant_onehot0 : assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(grant));

    a_sel_stable : assert property (@(posedge clock) disable iff (!reset_n)
        (s1_valid_q && !s2_adv) |=> $stable(sel_q));

    a_rsp_hold : assert property (@(posedge clock) disable iff (!reset_n)
        (rsp_valid_q && !rsp_ready) |=> (rsp_valid_q && $stable(rsp_data_q) && $stable(rsp_id_q)));

endmodule

// File: tb/tb_mux_read_arbiter.sv
// Bench for mux_read_arbiter: cycle model of arbitration/pipeline plus a response scoreboard.
module tb_mux_read_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 5;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [N*SW-1:0]   req_sel;
    logic [N-1:0]      grant;
    logic [SW-1:0]     mux_select;
    logic [DW-1:0]     mux_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_data;

    logic [DW-1:0]     mux_in [32];

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;

    logic              m_s1v;
    logic              m_rspv;
    logic [SW-1:0]     m_sel;
    int                m_ptr;
    int                w;
    logic              acc_en;
    logic [N-1:0]      exp_grant;
    exp_t              e;

    mux_read_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .SEL_WIDTH  (SW),
        .ID_WIDTH   (IW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .req_sel    (req_sel),
        .grant      (grant),
        .mux_select (mux_select),
        .mux_data   (mux_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    always #5 clock = ~clock;

    assign mux_data = mux_in[mux_select];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_sel(input int i, input int v);
        req_sel[i*SW +: SW] = SW'(v);
    endtask

    // Model evaluated mid-cycle: checks current outputs, then steps to the state after the next edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            m_s1v  = 1'b0;
            m_rspv = 1'b0;
            m_sel  = '0;
            m_ptr  = 0;
            exp_q.delete();
        end else begin
            acc_en = !m_s1v || !m_rspv || rsp_ready;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            exp_grant = '0;
            if (w >= 0 && acc_en) exp_grant[w] = 1'b1;

            check("grant", 32'(grant), 32'(exp_grant));
            check("mux_select", 32'(mux_select), 32'(m_sel));
            check("rsp_valid", 32'(rsp_valid), 32'(m_rspv));
            if (m_rspv && exp_q.size() > 0) begin
                check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                check("rsp_data", rsp_data, exp_q[0].data);
            end

            if (!m_rspv || rsp_ready) begin
                if (m_rspv && exp_q.size() > 0) void'(exp_q.pop_front());
                m_rspv = m_s1v;
            end
            if (acc_en) begin
                m_s1v = (w >= 0);
                if (w >= 0) begin
                    m_sel  = req_sel[w*SW +: SW];
                    m_ptr  = (w + 1) % N;
                    e.id   = IW'(w);
                    e.data = DW'(m_sel);
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 32; k++) mux_in[k] = DW'(k);
        reset_n   = 1'b1;
        req       = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;
        #2 reset_n = 1'b0;
        req = '1;
        #2;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_mux_select", 32'(mux_select), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        req = '0;
        cyc(3);
        reset_n = 1'b1;
        cyc(2);

        // single request
        req = 4'b0001;
        set_sel(0, 9);
        #1 check("single_grant", 32'(grant), 32'b0001);
        cyc(1);
        req = '0;
        check("single_mux", 32'(mux_select), 32'd9);
        cyc(1);
        check("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check("single_rsp_id", 32'(rsp_id), 32'd0);
        check("single_rsp_data", rsp_data, 32'd9);
        cyc(3);

        // full contention
        for (int i = 0; i < N; i++) set_sel(i, 10 + i);
        req = '1;
        cyc(8);
        req = '0;
        cyc(4);

        // backpressure after first response
        req = '1;
        cyc(2);
        rsp_ready = 1'b0;
        #1 check("bp_grant", 32'(grant), 32'd0);
        cyc(3);
        rsp_ready = 1'b1;
        cyc(4);
        req = '0;
        cyc(4);

        // pointer wrap from requester 3 back to 0
        req = 4'b1000;
        set_sel(3, 3);
        #1 check("wrap_grant3", 32'(grant), 32'b1000);
        cyc(1);
        req = 4'b1001;
        set_sel(0, 7);
        #1 check("wrap_grant0", 32'(grant), 32'b0001);
        cyc(1);
        req = 4'b1000;
        #1 check("wrap_grant3b", 32'(grant), 32'b1000);
        cyc(1);
        req = '0;
        cyc(4);

        // asynchronous reset with both stages full
        rsp_ready = 1'b0;
        req = '1;
        cyc(2);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_mux_select", 32'(mux_select), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        check("mid_rst_rsp_data", rsp_data, 32'd0);
        req = '0;
        rsp_ready = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(8);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        // idle hold of mux_select
        req = 4'b0100;
        set_sel(2, 21);
        cyc(1);
        req = '0;
        cyc(12);
        check("idle_mux", 32'(mux_select), 32'd21);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // random traffic with random backpressure
        for (int c = 0; c < 300; c++) begin
            req = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) set_sel(i, $urandom_range(0, 31));
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        req = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (exp_q.size() == 0) break;
            cyc(1);
        end
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
